// File: rtl/mem_pkg.sv
// Shared bus widths, FSM state type and data typedefs for the memory responder slice.
package mem_pkg;

  localparam int unsigned MEM_ADDR_W = 16;
  localparam int unsigned MEM_DATA_W = 32;

  typedef enum logic {
    INIT  = 1'b0,
    READY = 1'b1
  } mem_state_e;

  typedef logic [MEM_ADDR_W-1:0] mem_addr_t;
  typedef logic [MEM_DATA_W-1:0] mem_data_t;

  // Saturating increment used by the optional access counters.
  function automatic logic [31:0] sat_inc32(input logic [31:0] v);
    return (v == '1) ? v : v + 32'd1;
  endfunction

endpackage

// File: rtl/mem_rd_pipe.sv
// Fixed-depth read-data shift register with asynchronous clear; the last stage drives rdata.
module mem_rd_pipe
  import mem_pkg::*;
#(
  parameter int unsigned DATA_W = MEM_DATA_W,
  parameter int unsigned STAGES = 1
) (
  input  logic              clk,
  input  logic              arst_n,
  input  logic [DATA_W-1:0] din,
  output logic [DATA_W-1:0] dout
);

  logic [DATA_W-1:0] stage [STAGES];

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      for (int unsigned i = 0; i < STAGES; i++) begin
        stage[i] <= '0;
      end
    end else begin
      stage[0] <= din;
      for (int unsigned i = 1; i < STAGES; i++) begin
        stage[i] <= stage[i-1];
      end
    end
  end

  assign dout = stage[STAGES-1];

endmodule

// File: rtl/mem_responder.sv
// Memory-side bus responder: word array, post-reset clear sequencer, fixed-latency read pipe.
// Optional access counters (wr_count/rd_count) are built when MEM_RESPONDER_STATS_EN is defined.
module mem_responder
  import mem_pkg::*;
#(
  parameter int unsigned ADDR_W       = MEM_ADDR_W,
  parameter int unsigned DATA_W       = MEM_DATA_W,
  parameter int unsigned DEPTH        = 1024,
  parameter int unsigned READ_LATENCY = 1
) (
  input  logic              clk,
  input  logic              arst_n,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata,
  output logic              init_busy,
`ifdef MEM_RESPONDER_STATS_EN
  output logic [31:0]       wr_count,
  output logic [31:0]       rd_count,
`endif
  output logic              err_oob
);

  localparam int unsigned   IDX_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DEPTH - 1);
  localparam logic [ADDR_W:0]  DEPTH_X  = (ADDR_W + 1)'(DEPTH);

  if ((READ_LATENCY < 1) || (READ_LATENCY > 4)) begin : g_bad_latency
    $error("mem_responder: READ_LATENCY must be in 1..4");
  end
  if ((DEPTH < 1) || (64'(DEPTH) > (64'd1 << ADDR_W))) begin : g_bad_depth
    $error("mem_responder: DEPTH must be in 1..2**ADDR_W");
  end

  mem_state_e        state;
  mem_state_e        state_nxt;
  logic              clr_en;
  logic              acc_en;
  logic [IDX_W-1:0]  init_ptr;
  logic              in_range;
  logic [IDX_W-1:0]  idx;
  logic [DATA_W-1:0] pipe_din;
  logic              err_q;
  logic [DATA_W-1:0] mem [DEPTH];

  // Full-width compare so upper address bits never alias into the array.
  assign in_range = ({1'b0, addr} < DEPTH_X);
  assign idx      = addr[IDX_W-1:0];

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      state <= INIT;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      INIT:    if (init_ptr == LAST_IDX) state_nxt = READY;
      READY:   state_nxt = READY;
      default: state_nxt = INIT;
    endcase
  end

  always_comb begin
    init_busy = 1'b0;
    clr_en    = 1'b0;
    acc_en    = 1'b0;
    case (state)
      INIT: begin
        init_busy = 1'b1;
        clr_en    = 1'b1;
      end
      READY:   acc_en = 1'b1;
      default: init_busy = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      init_ptr <= '0;
    end else if (clr_en) begin
      init_ptr <= init_ptr + 1'b1;
    end
  end

  // The clear sequencer owns the single write port while INIT; bus writes are dropped.
  always_ff @(posedge clk) begin
    if (clr_en) begin
      mem[init_ptr] <= '0;
    end else if (acc_en && we && in_range) begin
      mem[idx] <= wdata;
    end
  end

  // Writes are echoed through the pipe; anything not accepted loads zero.
  always_comb begin
    pipe_din = '0;
    if (acc_en && in_range) begin
      pipe_din = we ? wdata : mem[idx];
    end
  end

  mem_rd_pipe #(
    .DATA_W (DATA_W),
    .STAGES (READ_LATENCY)
  ) u_rd_pipe (
    .clk    (clk),
    .arst_n (arst_n),
    .din    (pipe_din),
    .dout   (rdata)
  );

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      err_q <= 1'b0;
    end else begin
      err_q <= ~in_range;
    end
  end

  assign err_oob = err_q;

`ifdef MEM_RESPONDER_STATS_EN
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      wr_count <= '0;
      rd_count <= '0;
    end else if (acc_en && in_range) begin
      if (we) begin
        wr_count <= sat_inc32(wr_count);
      end else begin
        rd_count <= sat_inc32(rd_count);
      end
    end
  end
`endif

endmodule

// File: tb/tb_mem_responder.sv
// Self-checking bench: two responders (latency 1 and 3) on one bus, checked against a behavioural model.
module tb_mem_responder;
  import mem_pkg::*;

  localparam int unsigned DEPTH = 1024;

  logic      clk = 1'b0;
  logic      arst_n = 1'b0;
  logic      we = 1'b0;
  mem_addr_t addr = '0;
  mem_data_t wdata = '0;

  mem_data_t rdata1, rdata3;
  logic      busy1, busy3, oob1, oob3;
`ifdef MEM_RESPONDER_STATS_EN
  logic [31:0] wc1, rc1, wc3, rc3;
`endif

  int checks = 0;
  int failures = 0;

  // Behavioural model: array contents, remaining clear cycles, last three pipe loads.
  mem_data_t   mmem [DEPTH];
  int unsigned left;
  mem_data_t   hist [3];
  logic        exp_oob;
  logic        exp_busy;
  int unsigned m_wr, m_rd;

  always #5 clk = ~clk;

  mem_responder #(
    .ADDR_W(MEM_ADDR_W), .DATA_W(MEM_DATA_W), .DEPTH(DEPTH), .READ_LATENCY(1)
  ) u_dut1 (
    .clk(clk), .arst_n(arst_n), .we(we), .addr(addr), .wdata(wdata),
    .rdata(rdata1), .init_busy(busy1),
`ifdef MEM_RESPONDER_STATS_EN
    .wr_count(wc1), .rd_count(rc1),
`endif
    .err_oob(oob1)
  );

  mem_responder #(
    .ADDR_W(MEM_ADDR_W), .DATA_W(MEM_DATA_W), .DEPTH(DEPTH), .READ_LATENCY(3)
  ) u_dut3 (
    .clk(clk), .arst_n(arst_n), .we(we), .addr(addr), .wdata(wdata),
    .rdata(rdata3), .init_busy(busy3),
`ifdef MEM_RESPONDER_STATS_EN
    .wr_count(wc3), .rd_count(rc3),
`endif
    .err_oob(oob3)
  );

  task automatic model_reset();
    for (int i = 0; i < int'(DEPTH); i++) mmem[i] = '0;
    left = DEPTH;
    for (int i = 0; i < 3; i++) hist[i] = '0;
    exp_oob  = 1'b0;
    exp_busy = 1'b1;
    m_wr = 0;
    m_rd = 0;
  endtask

  // Drive one access, advance one edge, update the model, then settle 1 ns past the edge.
  task automatic cycle(input logic w, input mem_addr_t a, input mem_data_t d);
    mem_data_t ld;
    logic      inr;
    we = w; addr = a; wdata = d;
    @(posedge clk);
    inr = (int'(a) < int'(DEPTH));
    ld  = '0;
    if (left == 0 && inr) begin
      if (w) begin
        ld = d;
        mmem[int'(a)] = d;
        m_wr++;
      end else begin
        ld = mmem[int'(a)];
        m_rd++;
      end
    end
    if (left > 0) left--;
    hist[2] = hist[1];
    hist[1] = hist[0];
    hist[0] = ld;
    exp_oob  = ~inr;
    exp_busy = (left > 0);
    #1;
  endtask

  task automatic test_reset();
    model_reset();
    #12;
    checks++; if (rdata1 !== 32'h0) begin failures++; $display("FAIL reset_rdata1 got=%h want=%h", rdata1, 32'h0); end
    checks++; if (rdata3 !== 32'h0) begin failures++; $display("FAIL reset_rdata3 got=%h want=%h", rdata3, 32'h0); end
    checks++; if (busy1 !== 1'b1 || busy3 !== 1'b1) begin failures++; $display("FAIL reset_busy got=%b%b want=11", busy1, busy3); end
    checks++; if (oob1 !== 1'b0 || oob3 !== 1'b0) begin failures++; $display("FAIL reset_oob got=%b%b want=00", oob1, oob3); end
`ifdef MEM_RESPONDER_STATS_EN
    checks++; if ((wc1 | rc1 | wc3 | rc3) !== 32'h0) begin failures++; $display("FAIL reset_stats got=%h/%h want=0", wc1, rc1); end
`endif
    @(negedge clk);
    arst_n = 1'b1;
  endtask

  // Counts INIT cycles; a bus write at cycle 10 must be dropped.
  task automatic run_init(input string tag, input logic do_write);
    int n = 0;
    do begin
      n++;
      if (do_write && n == 10) cycle(1'b1, 16'h0020, 32'hFFFF_FFFF);
      else cycle(1'b0, 16'h0005, 32'h0);
      checks++; if (busy1 !== exp_busy || busy3 !== exp_busy) begin failures++; $display("FAIL %s_busy cyc=%0d got=%b%b want=%b", tag, n, busy1, busy3, exp_busy); end
      checks++; if (rdata1 !== 32'h0 || rdata3 !== 32'h0) begin failures++; $display("FAIL %s_rdata cyc=%0d got=%h/%h want=0", tag, n, rdata1, rdata3); end
    end while (busy1 === 1'b1 && n < 2000);
    checks++; if (n != 1024) begin failures++; $display("FAIL %s_len got=%0d want=1024", tag, n); end
  endtask

  task automatic test_init_write();
    run_init("init", 1'b1);
    cycle(1'b0, 16'h0005, 32'h0);
    checks++; if (rdata1 !== 32'h0) begin failures++; $display("FAIL init_read5 got=%h want=0", rdata1); end
    cycle(1'b0, 16'h0020, 32'h0);
    checks++; if (rdata1 !== 32'h0) begin failures++; $display("FAIL init_dropped_wr got=%h want=0", rdata1); end
    cycle(1'b0, 16'h0005, 32'h0);
    cycle(1'b0, 16'h0005, 32'h0);
    checks++; if (rdata3 !== 32'h0) begin failures++; $display("FAIL init_dropped_wr3 got=%h want=0", rdata3); end
  endtask

  task automatic test_write_read();
    cycle(1'b1, 16'h0010, 32'hDEAD_BEEF);
    checks++; if (rdata1 !== 32'hDEAD_BEEF) begin failures++; $display("FAIL wr_through1 got=%h want=%h", rdata1, 32'hDEAD_BEEF); end
    cycle(1'b0, 16'h0010, 32'h0);
    checks++; if (rdata1 !== 32'hDEAD_BEEF) begin failures++; $display("FAIL rd_after_wr1 got=%h want=%h", rdata1, 32'hDEAD_BEEF); end
    cycle(1'b0, 16'h0011, 32'h0);
    checks++; if (rdata3 !== 32'hDEAD_BEEF) begin failures++; $display("FAIL wr_through3 got=%h want=%h", rdata3, 32'hDEAD_BEEF); end
    cycle(1'b0, 16'h0011, 32'h0);
    checks++; if (rdata3 !== 32'hDEAD_BEEF) begin failures++; $display("FAIL rd_after_wr3 got=%h want=%h", rdata3, 32'hDEAD_BEEF); end
    checks++; if (rdata1 !== hist[0]) begin failures++; $display("FAIL rd_unwritten got=%h want=%h", rdata1, hist[0]); end
  endtask

  task automatic test_back_to_back();
    mem_data_t data [16];
    for (int i = 0; i < 16; i++) data[i] = $urandom;
    for (int i = 0; i < 16; i++) begin
      cycle(1'b1, mem_addr_t'(16'h0100 + i), data[i]);
      checks++; if (rdata1 !== hist[0] || rdata3 !== hist[2]) begin failures++; $display("FAIL b2b_wr i=%0d got=%h/%h want=%h/%h", i, rdata1, rdata3, hist[0], hist[2]); end
    end
    for (int j = 0; j < 16; j++) begin
      cycle(1'b0, mem_addr_t'(16'h0100 + j), 32'h0);
      checks++; if (rdata1 !== data[j]) begin failures++; $display("FAIL b2b_rd1 j=%0d got=%h want=%h", j, rdata1, data[j]); end
      checks++; if (rdata3 !== data[(j + 14) % 16]) begin failures++; $display("FAIL b2b_rd3 j=%0d got=%h want=%h", j, rdata3, data[(j + 14) % 16]); end
    end
    for (int k = 0; k < 2; k++) begin
      cycle(1'b0, 16'h0200, 32'h0);
      checks++; if (rdata3 !== data[14 + k]) begin failures++; $display("FAIL b2b_tail3 k=%0d got=%h want=%h", k, rdata3, data[14 + k]); end
    end
  endtask

  task automatic test_oob();
    cycle(1'b1, 16'h0000, 32'hA5A5_0001);
    cycle(1'b0, 16'h0400, 32'h0);
    checks++; if (oob1 !== 1'b1 || oob3 !== 1'b1) begin failures++; $display("FAIL oob_rd_flag got=%b%b want=11", oob1, oob3); end
    checks++; if (rdata1 !== 32'h0) begin failures++; $display("FAIL oob_rd_data got=%h want=0", rdata1); end
    cycle(1'b1, 16'h0400, 32'h1234_5678);
    checks++; if (oob1 !== 1'b1) begin failures++; $display("FAIL oob_wr_flag got=%b want=1", oob1); end
    cycle(1'b0, 16'h0000, 32'h0);
    checks++; if (oob1 !== 1'b0) begin failures++; $display("FAIL oob_pulse_end got=%b want=0", oob1); end
    checks++; if (rdata1 !== 32'hA5A5_0001) begin failures++; $display("FAIL oob_no_alias got=%h want=%h", rdata1, 32'hA5A5_0001); end
    cycle(1'b1, 16'h03FF, 32'h0BAD_F00D);
    checks++; if (oob1 !== 1'b0 || rdata1 !== 32'h0BAD_F00D) begin failures++; $display("FAIL top_word got=%b/%h want=0/%h", oob1, rdata1, 32'h0BAD_F00D); end
    cycle(1'b0, 16'hFFFF, 32'h0);
    checks++; if (oob1 !== 1'b1 || rdata1 !== 32'h0) begin failures++; $display("FAIL oob_ffff got=%b/%h want=1/0", oob1, rdata1); end
  endtask

  task automatic test_random();
    logic      w;
    mem_addr_t a;
    for (int i = 0; i < 400; i++) begin
      w = 1'($urandom_range(0, 1));
      case ($urandom_range(0, 3))
        0:       a = mem_addr_t'(16'h03F0 + $urandom_range(0, 31));
        1:       a = mem_addr_t'($urandom);
        default: a = mem_addr_t'($urandom_range(0, 63));
      endcase
      cycle(w, a, $urandom);
      checks++; if (rdata1 !== hist[0]) begin failures++; $display("FAIL rand_rd1 i=%0d got=%h want=%h", i, rdata1, hist[0]); end
      checks++; if (rdata3 !== hist[2]) begin failures++; $display("FAIL rand_rd3 i=%0d got=%h want=%h", i, rdata3, hist[2]); end
      checks++; if (oob1 !== exp_oob || oob3 !== exp_oob) begin failures++; $display("FAIL rand_oob i=%0d got=%b%b want=%b", i, oob1, oob3, exp_oob); end
    end
`ifdef MEM_RESPONDER_STATS_EN
    checks++; if (wc1 !== m_wr || wc3 !== m_wr) begin failures++; $display("FAIL stats_wr got=%0d/%0d want=%0d", wc1, wc3, m_wr); end
    checks++; if (rc1 !== m_rd || rc3 !== m_rd) begin failures++; $display("FAIL stats_rd got=%0d/%0d want=%0d", rc1, rc3, m_rd); end
`endif
  endtask

  task automatic test_reset_mid();
    cycle(1'b1, 16'h0030, 32'hCAFE_0001);
    cycle(1'b0, 16'h0030, 32'h0);
    cycle(1'b0, 16'h0030, 32'h0);
    checks++; if (rdata1 !== 32'hCAFE_0001) begin failures++; $display("FAIL mid_pre got=%h want=%h", rdata1, 32'hCAFE_0001); end
    #2;
    arst_n = 1'b0;
    model_reset();
    #1;
    checks++; if (rdata1 !== 32'h0 || rdata3 !== 32'h0) begin failures++; $display("FAIL mid_rdata got=%h/%h want=0", rdata1, rdata3); end
    checks++; if (busy1 !== 1'b1 || busy3 !== 1'b1) begin failures++; $display("FAIL mid_busy got=%b%b want=11", busy1, busy3); end
`ifdef MEM_RESPONDER_STATS_EN
    checks++; if ((wc1 | rc1 | wc3 | rc3) !== 32'h0) begin failures++; $display("FAIL mid_stats got=%h/%h want=0", wc1, rc1); end
`endif
    @(negedge clk);
    arst_n = 1'b1;
    run_init("reinit", 1'b0);
    cycle(1'b0, 16'h0030, 32'h0);
    checks++; if (rdata1 !== 32'h0) begin failures++; $display("FAIL reinit_cleared got=%h want=0", rdata1); end
  endtask

  initial begin
    test_reset();
    test_init_write();
    test_write_read();
    test_back_to_back();
    test_oob();
    test_random();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
